fifo_packer: RTL and testbench

FIFO_PACKER -- requirements
Module: fifo_packer

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_packer_if.sv | 28 ++
 rtl/pack_hold.sv | 50 +++++
 rtl/fifo_packer.sv | 93 +++++++++
 tb/tb_fifo_packer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the beat-to-word packer.
// Default widths, the packed-word width derivation and the beat-count type.
package fifo_pkg;

  localparam int DEF_IN_WIDTH = 4;
  localparam int DEF_RATIO    = 4;

  function automatic int out_width(input int in_width, input int ratio);
    return in_width * ratio;
  endfunction

  localparam int DEF_OUT_WIDTH = out_width(DEF_IN_WIDTH, DEF_RATIO);

  typedef logic [$clog2(DEF_RATIO)-1:0] beat_cnt_t;

endpackage

// File: rtl/fifo_packer_if.sv
// Beat input / packed-word output bundle of the packer.
// slave = packer side, master = producer + downstream FIFO side.
interface fifo_packer_if #(
  parameter int IN_WIDTH = fifo_pkg::DEF_IN_WIDTH,
  parameter int RATIO    = fifo_pkg::DEF_RATIO
);

  localparam int OUT_WIDTH = fifo_pkg::out_width(IN_WIDTH, RATIO);

  logic                 in_valid;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 in_ready;
  logic                 fifo_full;
  logic                 fifo_push;
  logic [OUT_WIDTH-1:0] fifo_wdata;

  modport slave (
    input  in_valid, in_data, in_last, fifo_full,
    output in_ready, fifo_push, fifo_wdata
  );

  modport master (
    output in_valid, in_data, in_last, fifo_full,
    input  in_ready, fifo_push, fifo_wdata
  );

endinterface

// File: rtl/pack_hold.sv
// One-entry hold register between the accumulator and the downstream FIFO.
// A load on the same edge as a push replaces the word so the stream has no bubble.
module pack_hold #(
  parameter int WIDTH = fifo_pkg::DEF_OUT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             fifo_full,
  output logic             hold_vld,
  output logic             fifo_push,
  output logic [WIDTH-1:0] fifo_wdata
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             push;

  always_comb begin
    push   = vld_q && !fifo_full && !flush;
    vld_d  = vld_q;
    data_d = data_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d  = 1'b1;
      data_d = load_data;
    end else if (push) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  // Outputs are forced quiet while reset is held, even before the first edge.
  assign hold_vld   = vld_q;
  assign fifo_push  = push && rst_n;
  assign fifo_wdata = rst_n ? data_q : '0;

endmodule

// File: rtl/fifo_packer.sv
// Packs RATIO beats of IN_WIDTH bits into one word and pushes it to a FIFO.
// Optional feature macro FIFO_PACKER_LAST_EN: in_last closes a word early, zero-padded.
module fifo_packer
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  parameter int RATIO    = DEF_RATIO
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  fifo_packer_if.slave             bus,
  output logic [$clog2(RATIO)-1:0] beat_cnt
);

  localparam int OUT_WIDTH = out_width(IN_WIDTH, RATIO);
  localparam int CW        = $clog2(RATIO);
  localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] word;
  logic                 hold_vld;
  logic                 accept;
  logic                 complete;
  logic                 last_term;

`ifdef FIFO_PACKER_LAST_EN
  assign last_term = bus.in_last;
`else
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
  assign last_term      = 1'b0;
`endif

  assign bus.in_ready = !flush &&
                        !(hold_vld && bus.fifo_full && ((cnt_q == LAST_IDX) || last_term));
  assign accept       = bus.in_valid && bus.in_ready && !flush;

  // Slots above cnt_q are always zero, so an early close is already zero-padded.
  always_comb begin
    word = acc_q;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_q == CW'(i)) word[i*IN_WIDTH +: IN_WIDTH] = bus.in_data;
    end
  end

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    if (flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if ((cnt_q == LAST_IDX) || last_term) begin
        complete = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        acc_d = word;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign beat_cnt = cnt_q;

  pack_hold #(
    .WIDTH (OUT_WIDTH)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .load       (complete),
    .load_data  (word),
    .fifo_full  (bus.fifo_full),
    .hold_vld   (hold_vld),
    .fifo_push  (bus.fifo_push),
    .fifo_wdata (bus.fifo_wdata)
  );

endmodule

// File: tb/tb_fifo_packer.sv
// Scoreboard bench for fifo_packer: directed scenarios followed by random traffic.
// The reference model works on a queue of pending beats and a queue of expected words.
module tb_fifo_packer;

  localparam int IW = 4;
  localparam int R  = 4;
  localparam int OW = IW * R;
`ifdef FIFO_PACKER_LAST_EN
  localparam bit LAST = 1'b1;
`else
  localparam bit LAST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [1:0] beat_cnt;

  fifo_packer_if #(.IN_WIDTH(IW), .RATIO(R)) bus ();

  fifo_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus.slave),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  bit          started = 1'b0;
  logic [OW-1:0] exp_q[$];
  int          part[$];
  bit          hold_pending = 1'b0;
  bit          exp_ready, exp_push;
  int          exp_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock cycle of stimulus, then the model absorbs what that edge did.
  task automatic cycle(input bit v, input int d, input bit l, input bit full,
                       input bit fl, input bit rn);
    logic [OW-1:0] w;
    bus.in_valid  = v;
    bus.in_data   = IW'(d);
    bus.in_last   = l;
    bus.fifo_full = full;
    flush         = fl;
    rst_n         = rn;
    exp_ready = !fl && !(hold_pending && full && (part.size() == R-1 || (LAST && l)));
    exp_push  = rn && hold_pending && !full && !fl;
    exp_cnt   = part.size();
    @(posedge clk);
    #1;
    if (!rn) begin
      part.delete();
      exp_q.delete();
      hold_pending = 1'b0;
    end else if (fl) begin
      part.delete();
      if (hold_pending && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      hold_pending = 1'b0;
    end else begin
      if (exp_push) hold_pending = 1'b0;
      if (v && exp_ready) begin
        part.push_back(d & ((1 << IW) - 1));
        if (part.size() == R || (LAST && l)) begin
          w = '0;
          foreach (part[i]) w = w | (OW'(part[i]) << (i * IW));
          exp_q.push_back(w);
          hold_pending = 1'b1;
          part.delete();
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 1);
  endtask

  always @(negedge clk) begin
    if (started) begin
      logic [OW-1:0] w;
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      chk("beat_cnt", 32'(beat_cnt), 32'(exp_cnt));
      chk("fifo_push", 32'(bus.fifo_push), 32'(exp_push));
      if (!rst_n) chk("wdata_in_reset", 32'(bus.fifo_wdata), 32'd0);
      if (bus.fifo_push === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_push", 32'(bus.fifo_wdata), 32'hFFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          chk("fifo_wdata", 32'(bus.fifo_wdata), 32'(w));
        end
      end
    end
  end

  initial begin
    cycle(0, 0, 0, 0, 0, 0);
    started = 1'b1;
    cycle(0, 0, 0, 0, 0, 0);
    idle(1);

    // four beats -> 4321
    for (int i = 1; i <= 4; i++) cycle(1, i, 0, 0, 0, 1);
    idle(2);

    // back-to-back 1..8 -> 4321, 8765
    for (int i = 1; i <= 8; i++) cycle(1, i, 0, 0, 0, 1);
    idle(3);

    // stalled hold: beats 5,6,7 accepted, beat 8 waits until full drops
    for (int i = 1; i <= 4; i++) cycle(1, i, 0, 1, 0, 1);
    for (int i = 5; i <= 7; i++) cycle(1, i, 0, 1, 0, 1);
    cycle(1, 8, 0, 1, 0, 1);
    cycle(1, 8, 0, 1, 0, 1);
    cycle(1, 8, 0, 0, 0, 1);
    idle(3);

    // flush discards A,B
    cycle(1, 10, 0, 0, 0, 1);
    cycle(1, 11, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 1);
    for (int i = 1; i <= 4; i++) cycle(1, i, 0, 0, 0, 1);
    idle(3);

    // early close with in_last on beat 6
    cycle(1, 5, 0, 0, 0, 1);
    cycle(1, 6, 1, 0, 0, 1);
    idle(3);
    cycle(1, 7, 0, 0, 0, 1);
    cycle(1, 8, 0, 0, 0, 1);
    idle(3);

    // reset mid-word
    for (int i = 1; i <= 3; i++) cycle(1, i, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 9, 0, 0, 0, 1);
    cycle(1, 10, 0, 0, 0, 1);
    cycle(1, 11, 0, 0, 0, 1);
    cycle(1, 12, 0, 0, 0, 1);
    idle(3);

    // flush while a word is stalled in the hold register
    for (int i = 1; i <= 4; i++) cycle(1, i, 0, 1, 0, 1);
    cycle(0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 1, 1, 1);
    idle(3);

    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 99) < 75,
            int'($urandom_range(0, 15)),
            $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) >= 1);
    end

    idle(6);
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
